hsem_ahb_arb: RTL and testbench
===============================

# hsem_ahb_arb

Two-master AHB-Lite arbiter that sits directly upstream of the HSEM slave port. It merges the bus traffic of core 0 and core 1 onto the single `hsem_top` AHB-Lite interface. It holds the losing master's address phase and inserts wait states into that master until its transfer completes. It also reports which core owns the current address phase (`s_hmaster`) so semaphore ownership can be tagged per core.

## Interface
- `ADDR_WIDTH`, 32, address width on all ports.
- `DATA_WIDTH`, 32, data width on all ports.
- `hclk`  in  1  single clock for the whole block.
- `hresetn`  in  1  asynchronous, active-low reset.
- `m<i>_hsel`, `m<i>_hwrite`, `m<i>_hmastlock` (i = 0, 1)  in  1 each  master i AHB-Lite address-phase controls.
- `m<i>_htrans`  in  2  master i transfer type; only bit 1 (NONSEQ/SEQ) counts as a request.
- `m<i>_hsize`, `m<i>_hburst`  in  3 each  master i transfer attributes.
- `m<i>_hprot`  in  4  master i protection attributes.
- `m<i>_haddr`  in  ADDR_WIDTH  master i address.
- `m<i>_hwdata`  in  DATA_WIDTH  master i write data.
- `m<i>_hreadyout`  out  1  master i HREADY.
- `m<i>_hresp`  out  2  master i response.
- `m<i>_hrdata`  out  DATA_WIDTH  master i read data.
- `s_hsel`, `s_hwrite`, `s_hmastlock`, `s_htrans`, `s_hsize`, `s_hburst`, `s_hprot`, `s_haddr`, `s_hwdata`  out  (same widths as above)  merged slave-side bus.
- `s_hready`  out  1  driven equal to `s_hreadyout`.
- `s_hmaster`  out  1  index of the address-phase owner.
- `s_hreadyout`  in  1  slave ready.
- `s_hresp`  in  2  slave response.
- `s_hrdata`  in  DATA_WIDTH  slave read data.

## Operation
- `live_i = m<i>_hsel & m<i>_htrans[1] & m<i>_hreadyout`. This is a newly presented address phase.
- Per-master hold register `hold_i` with flag `pend_i`:
  - `hold_i` holds haddr, htrans, hwrite, hsize, hburst, hprot and hmastlock.
  - `req_i = pend_i | live_i`.
  - The source for a request is `hold_i` if `pend_i` is set, otherwise the live master signals.
- `slv_rdy = !dp_valid | s_hreadyout`. A slave address phase is issued only when `slv_rdy` is 1.
- Arbitration, evaluated when `slv_rdy` = 1:
  - Only one of `req_0`/`req_1` set: that master wins.
  - Both set: the master that is not `last_grant` wins.
  - `last_grant` updates to the winner.
- Winner's source drives the `s_*` address signals, `s_hsel = 1` and `s_hmaster = winner`.
- No grant: `s_hsel = 0`, `s_htrans = 00`. The other `s_*` address signals are held at their last values.
- Capture: if `live_i` is set and master i is not granted (lost arbitration, or `slv_rdy` = 0), the request is loaded into `hold_i` and `pend_i` is set to 1.
- `pend_i` clears on the cycle its held request is granted.
- Data-phase tracking: on each grant, `dp_valid <= 1` and `dp_owner <= winner`. When `slv_rdy` = 1 with no grant, `dp_valid <= 0`.
- Write data: `s_hwdata = m<dp_owner>_hwdata`. The master's AHB wait-state rules keep its write data stable while its data phase is stalled.
- Master return path:
  - If `dp_valid` and `dp_owner` = i: `m<i>_hreadyout = s_hreadyout`, `m<i>_hresp = s_hresp`, `m<i>_hrdata = s_hrdata`.
  - Otherwise, if `pend_i`: `m<i>_hreadyout = 0`, hresp = OKAY.
  - Otherwise: `m<i>_hreadyout = 1`, hresp = OKAY, hrdata = 0.
- Invariant: `pend_i` and (`dp_valid` with `dp_owner` = i) are never both true.
- ERROR responses (both cycles) pass through unchanged. The arbiter never generates a response itself.

## Timing
- Reset values:
  - `pend_0`/`pend_1` = 0, `dp_valid` = 0, `dp_owner` = 0.
  - `last_grant` = 1, so master 0 wins the first tie.
  - `m<i>_hreadyout` = 1, `m<i>_hresp` = 00, `m<i>_hrdata` = 0.
  - `s_hsel` = 0, `s_htrans` = 00, `s_hmaster` = 0, `s_haddr` = 0.
- Uncontended master: zero added latency. The address passes combinationally in the same cycle.
- Losing master: exactly one extra wait state per contended transfer when the slave is zero-wait.
- Slave wait states: every stalled cycle is reflected on the owner only. A live request from the other master during a stall is captured and stays pending.
- Pipelined back-to-back transfers:
  - A master may present its next address in the last cycle of its own data phase.
  - Under contention, round-robin alternates the masters every transfer.
- Reset asserted mid-transfer clears all holds and the data-phase state immediately. No response is delivered for the aborted transfer.

## Configuration
- `HSEM_ARB_LOCK_EN` defined:
  - A grant with hmastlock = 1 sets `lock_valid`/`lock_owner`.
  - While locked, only `lock_owner` may be granted. The other master's request stays pending.
  - The lock clears on a grant to the owner with hmastlock = 0, or on a `slv_rdy` cycle in which the owner has no request.
- `HSEM_ARB_LOCK_EN` undefined: hmastlock is forwarded on `s_hmastlock` only and is ignored for arbitration.

## Test plan
- Reset with no requests -> both `m<i>_hreadyout` = 1, `s_hsel` = 0, `s_htrans` = 00, `s_hmaster` = 0.
- m0 single write to 0x10 with data 0xA5A5A5A5, slave zero-wait -> `s_haddr` = 0x10 in the same cycle, `s_hwdata` = 0xA5A5A5A5 the next cycle, m0 sees no wait state.
- m0 and m1 both issue NONSEQ in the same cycle -> m0 granted first, m1 gets `m1_hreadyout` = 0 for one cycle, `s_hmaster` goes 0 then 1. Repeating this -> m1 wins the next tie.
- Slave holds `s_hreadyout` = 0 for 2 cycles on an m0 read while m1 requests -> m1 is pending for 2 cycles and granted in the cycle m0 completes, m0 receives `s_hrdata`.
- Slave returns a two-cycle ERROR to m1 -> `m1_hresp` = 01 in both cycles, `m0_hresp` stays 00.
- With `HSEM_ARB_LOCK_EN`, m0 issues two locked transfers while m1 requests -> m1 is blocked until m0's unlocked transfer or idle, then granted.

Source files
------------

// File: rtl/hsem_ahb_arb.sv
// hsem_ahb_arb: two-master AHB-Lite arbiter in front of the HSEM slave port (round-robin on ties, reports owner on s_hmaster).
// Latency: an uncontended address phase reaches the slave combinationally; a losing master sees one extra wait state per contended transfer.
// Backpressure: slave wait states stall only the data-phase owner; the other master's request is parked and held with HREADYOUT low until granted.
// Build option: define HSEM_ARB_LOCK_EN to make hmastlock lock the bus to its owner during arbitration.
module hsem_ahb_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    // master 0
    input  logic                  m0_hsel,
    input  logic                  m0_hwrite,
    input  logic                  m0_hmastlock,
    input  logic [1:0]            m0_htrans,
    input  logic [2:0]            m0_hsize,
    input  logic [2:0]            m0_hburst,
    input  logic [3:0]            m0_hprot,
    input  logic [ADDR_WIDTH-1:0] m0_haddr,
    input  logic [DATA_WIDTH-1:0] m0_hwdata,
    output logic                  m0_hreadyout,
    output logic [1:0]            m0_hresp,
    output logic [DATA_WIDTH-1:0] m0_hrdata,
    // master 1
    input  logic                  m1_hsel,
    input  logic                  m1_hwrite,
    input  logic                  m1_hmastlock,
    input  logic [1:0]            m1_htrans,
    input  logic [2:0]            m1_hsize,
    input  logic [2:0]            m1_hburst,
    input  logic [3:0]            m1_hprot,
    input  logic [ADDR_WIDTH-1:0] m1_haddr,
    input  logic [DATA_WIDTH-1:0] m1_hwdata,
    output logic                  m1_hreadyout,
    output logic [1:0]            m1_hresp,
    output logic [DATA_WIDTH-1:0] m1_hrdata,
    // merged slave side
    output logic                  s_hsel,
    output logic                  s_hwrite,
    output logic                  s_hmastlock,
    output logic [1:0]            s_htrans,
    output logic [2:0]            s_hsize,
    output logic [2:0]            s_hburst,
    output logic [3:0]            s_hprot,
    output logic [ADDR_WIDTH-1:0] s_haddr,
    output logic [DATA_WIDTH-1:0] s_hwdata,
    output logic                  s_hready,
    output logic                  s_hmaster,
    input  logic                  s_hreadyout,
    input  logic [1:0]            s_hresp,
    input  logic [DATA_WIDTH-1:0] s_hrdata
);

    // Address-phase attributes that travel together through the hold registers.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] haddr;
        logic [1:0]            htrans;
        logic                  hwrite;
        logic [2:0]            hsize;
        logic [2:0]            hburst;
        logic [3:0]            hprot;
        logic                  hmastlock;
    } hdr_t;

    hdr_t                  m_ap [2];     // live address phase from each master
    hdr_t                  hold [2];     // parked address phase of a waiting master
    hdr_t                  src  [2];     // request source per master (hold or live)
    hdr_t                  win_ap;       // address phase of the current winner
    hdr_t                  last_ap;      // last address phase driven to the slave
    hdr_t                  s_ap;

    logic [1:0]            m_hsel;
    logic [1:0]            pend;
    logic [1:0]            live;
    logic [1:0]            req;
    logic [1:0]            elig;
    logic [1:0]            rdy_v;
    logic [1:0]            resp_v [2];
    logic [DATA_WIDTH-1:0] rdata_v [2];

    logic                  dp_vld;
    logic                  dp_owner;
    logic                  last_grant;
    logic                  hmaster_q;
    logic                  slv_rdy;
    logic                  gnt_vld;
    logic                  winner;

    assign m_ap[0] = {m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hburst, m0_hprot, m0_hmastlock};
    assign m_ap[1] = {m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hburst, m1_hprot, m1_hmastlock};
    assign m_hsel  = {m1_hsel, m0_hsel};

    // The slave can take a new address phase once the current data phase (if any) completes.
    assign slv_rdy = !dp_vld || s_hreadyout;

    // Return path: the data-phase owner sees the slave, a parked master is stalled, anyone else idles ready.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (dp_vld && (dp_owner == 1'(i))) begin
                rdy_v[i]   = s_hreadyout;
                resp_v[i]  = s_hresp;
                rdata_v[i] = s_hrdata;
            end else if (pend[i]) begin
                rdy_v[i]   = 1'b0;
                resp_v[i]  = 2'b00;
                rdata_v[i] = '0;
            end else begin
                rdy_v[i]   = 1'b1;
                resp_v[i]  = 2'b00;
                rdata_v[i] = '0;
            end
        end
    end

    assign m0_hreadyout = rdy_v[0];
    assign m0_hresp     = resp_v[0];
    assign m0_hrdata    = rdata_v[0];
    assign m1_hreadyout = rdy_v[1];
    assign m1_hresp     = resp_v[1];
    assign m1_hrdata    = rdata_v[1];

    // A new address phase counts only when the master's own HREADY accepts it; parked requests take priority as source.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            live[i] = m_hsel[i] && m_ap[i].htrans[1] && rdy_v[i];
            req[i]  = pend[i] || live[i];
            src[i]  = pend[i] ? hold[i] : m_ap[i];
        end
    end

`ifdef HSEM_ARB_LOCK_EN
    logic lock_vld;
    logic lock_owner;

    // While a locked sequence is open only its owner is eligible; the other request stays parked.
    always_comb begin
        elig = req;
        if (lock_vld) begin
            elig = lock_owner ? (req & 2'b10) : (req & 2'b01);
        end
    end

    // Lock follows each grant's hmastlock; an arbitration slot with no owner request releases it.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            lock_vld   <= 1'b0;
            lock_owner <= 1'b0;
        end else if (slv_rdy) begin
            if (gnt_vld) begin
                lock_vld   <= win_ap.hmastlock;
                lock_owner <= winner;
            end else begin
                lock_vld   <= 1'b0;
            end
        end
    end
`else
    // hmastlock is only forwarded to the slave; it never restricts arbitration.
    assign elig = req;
`endif

    // Round-robin: a sole requester wins, a tie goes to the master not granted last.
    always_comb begin
        gnt_vld = slv_rdy && (elig != 2'b00);
        winner  = (elig == 2'b11) ? ~last_grant : elig[1];
        win_ap  = winner ? src[1] : src[0];
    end

    // Slave address phase: winner's attributes, otherwise keep the last ones with an IDLE transfer.
    assign s_ap        = gnt_vld ? win_ap : last_ap;
    assign s_hsel      = gnt_vld;
    assign s_htrans    = gnt_vld ? s_ap.htrans : 2'b00;
    assign s_haddr     = s_ap.haddr;
    assign s_hwrite    = s_ap.hwrite;
    assign s_hsize     = s_ap.hsize;
    assign s_hburst    = s_ap.hburst;
    assign s_hprot     = s_ap.hprot;
    assign s_hmastlock = s_ap.hmastlock;
    assign s_hmaster   = gnt_vld ? winner : hmaster_q;
    assign s_hready    = s_hreadyout;

    // Write data belongs to the data-phase owner; AHB keeps it stable while that phase is stalled.
    assign s_hwdata = dp_owner ? m1_hwdata : m0_hwdata;

    // Park losing/stalled requests, retire them on grant, and track the data-phase owner.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pend       <= 2'b00;
            hold[0]    <= '0;
            hold[1]    <= '0;
            dp_vld     <= 1'b0;
            dp_owner   <= 1'b0;
            last_grant <= 1'b1;
            hmaster_q  <= 1'b0;
            last_ap    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (live[i] && !(gnt_vld && (winner == 1'(i)))) begin
                    hold[i] <= m_ap[i];
                    pend[i] <= 1'b1;
                end else if (gnt_vld && (winner == 1'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
            if (gnt_vld) begin
                dp_vld     <= 1'b1;
                dp_owner   <= winner;
                last_grant <= winner;
                hmaster_q  <= winner;
                last_ap    <= win_ap;
            end else if (slv_rdy) begin
                dp_vld     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hsem_ahb_arb.sv
// tb_hsem_ahb_arb: directed cycle vectors for hsem_ahb_arb with a queued scoreboard.
// Each vector drives one cycle and queues its hand-computed outputs; a monitor pops and compares mid-cycle.
// Lock-specific expectations follow the HSEM_ARB_LOCK_EN build option.
module tb_hsem_ahb_arb;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        m0_hsel, m0_hwrite, m0_hmastlock, m1_hsel, m1_hwrite, m1_hmastlock;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [2:0]  m0_hsize, m0_hburst, m1_hsize, m1_hburst;
    logic [3:0]  m0_hprot, m1_hprot;
    logic [31:0] m0_haddr, m0_hwdata, m1_haddr, m1_hwdata;
    logic        m0_hreadyout, m1_hreadyout;
    logic [1:0]  m0_hresp, m1_hresp;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        s_hsel, s_hwrite, s_hmastlock, s_hready, s_hmaster, s_hreadyout;
    logic [1:0]  s_htrans, s_hresp;
    logic [2:0]  s_hsize, s_hburst;
    logic [3:0]  s_hprot;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;

    hsem_ahb_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_hsel(m0_hsel), .m0_hwrite(m0_hwrite), .m0_hmastlock(m0_hmastlock), .m0_htrans(m0_htrans),
        .m0_hsize(m0_hsize), .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_haddr(m0_haddr),
        .m0_hwdata(m0_hwdata), .m0_hreadyout(m0_hreadyout), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
        .m1_hsel(m1_hsel), .m1_hwrite(m1_hwrite), .m1_hmastlock(m1_hmastlock), .m1_htrans(m1_htrans),
        .m1_hsize(m1_hsize), .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_haddr(m1_haddr),
        .m1_hwdata(m1_hwdata), .m1_hreadyout(m1_hreadyout), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
        .s_hsel(s_hsel), .s_hwrite(s_hwrite), .s_hmastlock(s_hmastlock), .s_htrans(s_htrans),
        .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hprot(s_hprot), .s_haddr(s_haddr),
        .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hmaster(s_hmaster),
        .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        int          step;
        logic [1:0]  rdy;
        logic        sel;
        logic        mst;
        logic [31:0] addr;
        logic [1:0]  rsp0;
        logic [1:0]  rsp1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        wchk;
        logic [31:0] wd;
        logic        hready;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_no  = 0;

    task automatic chk(input string nm, input int stp, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h want %h", nm, stp, act, want);
        end
    endtask

    // Drive one cycle of master/slave inputs, queue the expected outputs, then advance to the next edge.
    task automatic cyc(input logic [1:0] sel, input logic [1:0] nsq, input logic [1:0] wr, input logic [1:0] lk,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                       input logic srdy, input logic [1:0] srsp, input logic [31:0] srd,
                       input logic [1:0] e_rdy, input logic e_sel, input logic e_mst, input logic [31:0] e_addr,
                       input logic [1:0] e_rsp0, input logic [1:0] e_rsp1, input logic [31:0] e_rd0,
                       input logic [31:0] e_rd1, input logic wchk, input logic [31:0] e_wd);
        exp_t e;
        m0_hsel = sel[0];  m0_htrans = nsq[0] ? 2'b10 : 2'b00;  m0_hwrite = wr[0];  m0_hmastlock = lk[0];
        m1_hsel = sel[1];  m1_htrans = nsq[1] ? 2'b10 : 2'b00;  m1_hwrite = wr[1];  m1_hmastlock = lk[1];
        m0_haddr = a0;  m1_haddr = a1;  m0_hwdata = d0;  m1_hwdata = d1;
        s_hreadyout = srdy;  s_hresp = srsp;  s_hrdata = srd;
        step_no++;
        e.step = step_no;  e.rdy = e_rdy;  e.sel = e_sel;  e.mst = e_mst;  e.addr = e_addr;
        e.rsp0 = e_rsp0;  e.rsp1 = e_rsp1;  e.rd0 = e_rd0;  e.rd1 = e_rd1;  e.wchk = wchk;  e.wd = e_wd;
        e.hready = srdy;
        exp_q.push_back(e);
        @(posedge hclk);
        #1;
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare it mid-cycle against the queued record.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_hreadyout", e.step, {30'd0, m1_hreadyout, m0_hreadyout}, {30'd0, e.rdy});
                chk("s_hsel",      e.step, {31'd0, s_hsel}, {31'd0, e.sel});
                chk("s_htrans",    e.step, {30'd0, s_htrans}, e.sel ? 32'd2 : 32'd0);
                chk("s_hmaster",   e.step, {31'd0, s_hmaster}, {31'd0, e.mst});
                chk("s_haddr",     e.step, s_haddr, e.addr);
                chk("m0_hresp",    e.step, {30'd0, m0_hresp}, {30'd0, e.rsp0});
                chk("m1_hresp",    e.step, {30'd0, m1_hresp}, {30'd0, e.rsp1});
                chk("m0_hrdata",   e.step, m0_hrdata, e.rd0);
                chk("m1_hrdata",   e.step, m1_hrdata, e.rd1);
                chk("s_hready",    e.step, {31'd0, s_hready}, {31'd0, e.hready});
                if (e.wchk) chk("s_hwdata", e.step, s_hwdata, e.wd);
            end
        end
    end

    initial begin
        hresetn = 1'b0;
        m0_hsize = 3'b010;  m0_hburst = 3'b000;  m0_hprot = 4'b0011;
        m1_hsize = 3'b010;  m1_hburst = 3'b000;  m1_hprot = 4'b0011;
        @(posedge hclk);
        #1;
        // reset with no requests
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'hDEADBEEF, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'hDEADBEEF, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        hresetn = 1'b1;
        // tie after reset: m0 first, m1 parked one cycle, then granted from its hold register
        cyc(2'b11, 2'b11, 2'b10, 2'b00, 32'h20, 32'h24, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b1, 1'b0, 32'h20, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h5A5A0001, 1'b1, 2'b00, 32'hCAFE0000, 2'b01, 1'b1, 1'b1, 32'h24, 2'b00, 2'b00, 32'hCAFE0000, 32'h0, 1'b0, 32'h0);
        // tie while m1 owns the data phase: last grant was m1, so m0 wins; m1 write data on slave
        cyc(2'b11, 2'b11, 2'b00, 2'b00, 32'h30, 32'h34, 32'h0, 32'h5A5A0001, 1'b1, 2'b00, 32'hBEEF0001, 2'b11, 1'b1, 1'b0, 32'h30, 2'b00, 2'b00, 32'h0, 32'hBEEF0001, 1'b1, 32'h5A5A0001);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'hBEEF0002, 2'b01, 1'b1, 1'b1, 32'h34, 2'b00, 2'b00, 32'hBEEF0002, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'hBEEF0003, 2'b11, 1'b0, 1'b1, 32'h34, 2'b00, 2'b00, 32'h0, 32'hBEEF0003, 1'b0, 32'h0);
        // m0 single write to 0x10, zero added latency, data follows next cycle
        cyc(2'b01, 2'b01, 2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b1, 1'b0, 32'h10, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b1, 2'b00, 32'h77, 2'b11, 1'b0, 1'b0, 32'h10, 2'b00, 2'b00, 32'h77, 32'h0, 1'b1, 32'hA5A5A5A5);
        // tie after an m0 grant: m1 wins, m0 waits one cycle
        cyc(2'b11, 2'b11, 2'b00, 2'b00, 32'h40, 32'h44, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b1, 1'b1, 32'h44, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h88, 2'b10, 1'b1, 1'b0, 32'h40, 2'b00, 2'b00, 32'h0, 32'h88, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h99, 2'b11, 1'b0, 1'b0, 32'h40, 2'b00, 2'b00, 32'h99, 32'h0, 1'b0, 32'h0);
        // m0 read stalled two cycles by the slave while m1 requests
        cyc(2'b01, 2'b01, 2'b00, 2'b00, 32'h50, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b1, 1'b0, 32'h50, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b10, 2'b10, 2'b00, 2'b00, 32'h0, 32'h54, 32'h0, 32'h0, 1'b0, 2'b00, 32'hAAAA, 2'b10, 1'b0, 1'b0, 32'h50, 2'b00, 2'b00, 32'hAAAA, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 32'hBBBB, 2'b00, 1'b0, 1'b0, 32'h50, 2'b00, 2'b00, 32'hBBBB, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h12345678, 2'b01, 1'b1, 1'b1, 32'h54, 2'b00, 2'b00, 32'h12345678, 32'h0, 1'b0, 32'h0);
        // two-cycle ERROR to m1 passes through; m0 stays OKAY
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0, 2'b01, 1'b0, 1'b1, 32'h54, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01, 32'h0, 2'b11, 1'b0, 1'b1, 32'h54, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0, 32'h0);
        // no data-phase owner: a stray slave response is not forwarded
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01, 32'h3333, 2'b11, 1'b0, 1'b1, 32'h54, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        // hsel without NONSEQ and NONSEQ without hsel are not requests
        cyc(2'b10, 2'b01, 2'b00, 2'b00, 32'h58, 32'h5C, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b0, 1'b1, 32'h54, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        // reset in the middle of a contended transfer clears everything
        cyc(2'b11, 2'b11, 2'b00, 2'b00, 32'h60, 32'h64, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b1, 1'b0, 32'h60, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        hresetn = 1'b0;
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h5555, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        hresetn = 1'b1;
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h5555, 2'b11, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b11, 2'b11, 2'b00, 2'b00, 32'h70, 32'h74, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b1, 1'b0, 32'h70, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h6666, 2'b01, 1'b1, 1'b1, 32'h74, 2'b00, 2'b00, 32'h6666, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h7777, 2'b11, 1'b0, 1'b1, 32'h74, 2'b00, 2'b00, 32'h0, 32'h7777, 1'b0, 32'h0);
        // locked m0 transfer with m1 contending
        cyc(2'b11, 2'b11, 2'b00, 2'b01, 32'h80, 32'h84, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b1, 1'b0, 32'h80, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
`ifdef HSEM_ARB_LOCK_EN
        // second locked transfer keeps the bus; unlocked third releases it; then m1
        cyc(2'b01, 2'b01, 2'b00, 2'b01, 32'h88, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b01, 1'b1, 1'b0, 32'h88, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b01, 2'b01, 2'b00, 2'b00, 32'h8C, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b01, 1'b1, 1'b0, 32'h8C, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b01, 1'b1, 1'b1, 32'h84, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b0, 1'b1, 32'h84, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        // lock released by an idle owner slot; m1 waits one cycle then wins
        cyc(2'b01, 2'b01, 2'b00, 2'b01, 32'h90, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b1, 1'b0, 32'h90, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b10, 2'b10, 2'b00, 2'b00, 32'h0, 32'h94, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b0, 1'b0, 32'h90, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b01, 1'b1, 1'b1, 32'h94, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b0, 1'b1, 32'h94, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
`else
        // hmastlock ignored: round-robin hands the bus to m1, m0's second transfer parks
        cyc(2'b01, 2'b01, 2'b00, 2'b01, 32'h88, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b01, 1'b1, 1'b1, 32'h84, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b10, 1'b1, 1'b0, 32'h88, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b0, 1'b0, 32'h88, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b01, 2'b01, 2'b00, 2'b01, 32'h90, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b1, 1'b0, 32'h90, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b10, 2'b10, 2'b00, 2'b00, 32'h0, 32'h94, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b1, 1'b1, 32'h94, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0, 2'b11, 1'b0, 1'b1, 32'h94, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
`endif
        // drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge hclk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
